// File: rtl/imm_gen_pipe_pkg.sv
// Shared types for the RV32I immediate generator pipeline.
// IMM_GEN_PC_TARGET_EN adds a branch/jump target field to each stage entry.
package imm_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_U = 3'b001,
    IMM_S = 3'b010,
    IMM_B = 3'b011,
    IMM_J = 3'b100
  } imm_fmt_e;

  // The entry's pc is folded into its target as it enters stage 0.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] imm;
    logic            fmt_err;
`ifdef IMM_GEN_PC_TARGET_EN
    logic [XLEN-1:0] tgt;
`endif
  } imm_stage_t;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational RV32I immediate decoder: I/U/S/B/J formats, architecturally shifted.
// Reserved format selects yield a zero immediate with fmt_err_o set.
module imm_decode
  import imm_pkg::*;
(
  input  logic [XLEN-1:0] instr_i,
  input  logic [2:0]      immsrc_i,
  output logic [XLEN-1:0] imm_o,
  output logic            fmt_err_o
);

  always_comb begin
    imm_o     = '0;
    fmt_err_o = 1'b0;
    case (immsrc_i)
      IMM_I:   imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_U:   imm_o = {instr_i[31:12], 12'b0};
      IMM_S:   imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:   imm_o = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_J:   imm_o = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      default: fmt_err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Elastic STAGES-deep immediate generator with valid/ready handshakes and flush.
// Define IMM_GEN_PC_TARGET_EN to add the pc input and registered target output.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int IMMSRC_WIDTH = 3,
  parameter int STAGES       = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   instr,
  input  logic [IMMSRC_WIDTH-1:0] immsrc,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   immop,
`ifdef IMM_GEN_PC_TARGET_EN
  input  logic [DATA_WIDTH-1:0]   pc,
  output logic [DATA_WIDTH-1:0]   target,
`endif
  output logic                    fmt_err
);

  if (DATA_WIDTH != XLEN) begin : g_bad_width
    $error("imm_gen_pipe: DATA_WIDTH must be 32");
  end
  if (IMMSRC_WIDTH != 3) begin : g_bad_src
    $error("imm_gen_pipe: IMMSRC_WIDTH must be 3");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("imm_gen_pipe: STAGES must be in 1..4");
  end

  imm_stage_t            stage_q [STAGES];
  imm_stage_t            stage_d [STAGES];
  logic [STAGES-1:0]     adv;
  logic [DATA_WIDTH-1:0] dec_imm;
  logic                  dec_err;
  logic                  accept;

  imm_decode u_dec (
    .instr_i   (instr),
    .immsrc_i  (immsrc),
    .imm_o     (dec_imm),
    .fmt_err_o (dec_err)
  );

  // A valid stage advances when the output drains or any later stage has a hole.
  always_comb begin
    adv = '0;
    for (int k = 0; k < STAGES; k++) begin
      adv[k] = stage_q[k].valid && out_ready;
      for (int j = k + 1; j < STAGES; j++)
        if (!stage_q[j].valid) adv[k] = stage_q[k].valid;
    end
  end

  assign in_ready = !stage_q[0].valid || adv[0];
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    stage_d = stage_q;
    if (in_ready) begin
      stage_d[0].valid = accept;
      if (accept) begin
        stage_d[0].imm     = dec_imm;
        stage_d[0].fmt_err = dec_err;
`ifdef IMM_GEN_PC_TARGET_EN
        stage_d[0].tgt     = pc + dec_imm;
        if (immsrc == IMM_I) stage_d[0].tgt[0] = 1'b0;
`endif
      end
    end
    for (int k = 1; k < STAGES; k++) begin
      if (!stage_q[k].valid || adv[k]) begin
        if (stage_q[k-1].valid) stage_d[k] = stage_q[k-1];
        else                    stage_d[k].valid = 1'b0;
      end
    end
    if (flush)
      for (int k = 0; k < STAGES; k++) stage_d[k].valid = 1'b0;
  end

  // Stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) stage_q[k] <= stage_d[k];
    end
  end

  assign out_valid = stage_q[STAGES-1].valid;
  assign immop     = stage_q[STAGES-1].imm;
  assign fmt_err   = stage_q[STAGES-1].fmt_err;
`ifdef IMM_GEN_PC_TARGET_EN
  assign target    = stage_q[STAGES-1].tgt;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomized and directed bench for imm_gen_pipe against a queue-based reference model.
module tb_imm_gen_pipe;
  localparam int STAGES = 2;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready, fmt_err;
  logic [31:0] instr, immop, pc_v;
  logic [2:0]  immsrc;
`ifdef IMM_GEN_PC_TARGET_EN
  logic [31:0] target;
`endif

  int ncomp = 0, nfail = 0, edges = 0, npop = 0;

  typedef struct {
    logic [31:0] imm;
    logic        err;
    logic [31:0] tgt;
    int          acc;
  } exp_t;
  exp_t        q[$];
  int          pop_edge[$];
  logic [31:0] pop_imm[$];
  logic [31:0] last_imm, last_tgt, held_imm;
  logic        last_err, last_rdy, last_ov, held, held_err;
  int          last_lat;

  imm_gen_pipe #(.DATA_WIDTH(32), .IMMSRC_WIDTH(3), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .immsrc(immsrc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .immop(immop),
`ifdef IMM_GEN_PC_TARGET_EN
    .pc(pc_v), .target(target),
`endif
    .fmt_err(fmt_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference immediates built from sign-propagating shifts and masks.
  function automatic logic [31:0] ref_imm(input logic [31:0] ins, input logic [2:0] src);
    logic [31:0] sx20, sx19, sx11;
    sx20 = $signed(ins) >>> 20;
    sx19 = $signed(ins) >>> 19;
    sx11 = $signed(ins) >>> 11;
    case (src)
      3'd0: return sx20;
      3'd1: return ins & 32'hFFFFF000;
      3'd2: return (sx20 & ~32'h1F) | ((ins >> 7) & 32'h1F);
      3'd3: return (sx19 & 32'hFFFFF000) | ((ins << 4) & 32'h800) |
                   ((ins >> 20) & 32'h7E0) | ((ins >> 7) & 32'h1E);
      3'd4: return (sx11 & 32'hFFF00000) | (ins & 32'h000FF000) |
                   ((ins >> 9) & 32'h800) | ((ins >> 20) & 32'h7FE);
      default: return 32'h0;
    endcase
  endfunction

  // One clock: sample at the falling edge, update the model, step past the rising edge.
  task automatic cyc();
    exp_t e;
    logic exp_rdy, exp_ov;
    @(negedge clk);
    exp_ov  = (q.size() > 0) ? (edges - q[0].acc >= STAGES) : 1'b0;
    exp_rdy = (q.size() < STAGES) || out_ready;
    last_rdy = in_ready;
    last_ov  = out_valid;
    check("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
    check("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    if (held) begin
      check("hold_imm", immop, held_imm);
      check("hold_err", {31'b0, fmt_err}, {31'b0, held_err});
    end
    held = out_valid && !out_ready;
    held_imm = immop;
    held_err = fmt_err;
    if (out_valid && out_ready && q.size() > 0) begin
      e = q.pop_front();
      check("immop", immop, e.imm);
      check("fmt_err", {31'b0, fmt_err}, {31'b0, e.err});
`ifdef IMM_GEN_PC_TARGET_EN
      check("target", target, e.tgt);
`endif
      last_imm = immop;
      last_err = fmt_err;
      last_tgt = e.tgt;
      last_lat = edges - e.acc;
      npop++;
      pop_edge.push_back(edges);
      pop_imm.push_back(immop);
    end
    if (flush) begin
      q.delete();
      held = 1'b0;
    end else if (in_valid && exp_rdy) begin
      e.imm = ref_imm(instr, immsrc);
      e.err = (immsrc > 3'd4);
      e.tgt = pc_v + e.imm;
      if (immsrc == 3'd0) e.tgt[0] = 1'b0;
      e.acc = edges;
      q.push_back(e);
    end
    @(posedge clk);
    edges++;
    #1;
  endtask

  task automatic one(input string tag, input logic [31:0] ins, input logic [2:0] src,
                     input logic [31:0] pcv, input logic [31:0] eimm, input logic eerr,
                     input logic [31:0] etgt);
    int n0 = npop;
    int guard = 0;
    instr = ins; immsrc = src; pc_v = pcv; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    while (npop == n0 && guard < 20) begin
      cyc();
      guard++;
    end
    check({tag, "_seen"}, (npop != n0) ? 32'd1 : 32'd0, 32'd1);
    check({tag, "_imm"}, last_imm, eimm);
    check({tag, "_err"}, {31'b0, last_err}, {31'b0, eerr});
    check({tag, "_lat"}, last_lat, STAGES);
`ifdef IMM_GEN_PC_TARGET_EN
    check({tag, "_tgt"}, last_tgt, etgt);
`else
    if (etgt != last_tgt) last_tgt = etgt;
`endif
  endtask

  initial begin
    int n0;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    instr = '0; immsrc = '0; pc_v = '0; held = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_immop", immop, 32'd0);
    check("rst_fmt_err", {31'b0, fmt_err}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    one("I", 32'hFFF00093, 3'd0, 32'h0, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE);
    one("U", 32'h123450B7, 3'd1, 32'h0, 32'h12345000, 1'b0, 32'h12345000);
    one("J", 32'h001000EF, 3'd4, 32'h0, 32'h00000800, 1'b0, 32'h00000800);
    one("S", 32'hFE20AE23, 3'd2, 32'h0, 32'hFFFFFFFC, 1'b0, 32'hFFFFFFFC);
    one("B", 32'hFE000CE3, 3'd3, 32'h00001000, 32'hFFFFFFF8, 1'b0, 32'h00000FF8);
    one("Ipc", 32'h00300093, 3'd0, 32'h00001000, 32'h00000003, 1'b0, 32'h00001002);
    one("ILL", 32'hFFFFFFFF, 3'd7, 32'h0, 32'h0, 1'b1, 32'h0);

    // Backpressure: A, B, C back-to-back with the consumer stalled for 4 cycles.
    out_ready = 1'b0;
    pop_imm.delete(); pop_edge.delete();
    in_valid = 1'b1;
    instr = 32'h123450B7; immsrc = 3'd1; cyc();
    instr = 32'hFE000CE3; immsrc = 3'd3; cyc();
    instr = 32'hFFF00093; immsrc = 3'd0; cyc();
    check("bp_in_ready_low", {31'b0, last_rdy}, 32'd0);
    cyc();
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    repeat (4) cyc();
    check("bp_count", pop_imm.size(), 3);
    if (pop_imm.size() == 3) begin
      check("bp_A", pop_imm[0], 32'h12345000);
      check("bp_B", pop_imm[1], 32'hFFFFFFF8);
      check("bp_C", pop_imm[2], 32'hFFFFFFFF);
      check("bp_gap1", pop_edge[1] - pop_edge[0], 1);
      check("bp_gap2", pop_edge[2] - pop_edge[1], 1);
    end

    // Flush with two entries in flight and a concurrent input.
    in_valid = 1'b1;
    instr = 32'h123450B7; immsrc = 3'd1; cyc();
    instr = 32'hFE20AE23; immsrc = 3'd2; cyc();
    instr = 32'h001000EF; immsrc = 3'd4; flush = 1'b1; cyc();
    flush = 1'b0; in_valid = 1'b0;
    cyc();
    check("flush_out_valid", {31'b0, last_ov}, 32'd0);
    repeat (3) cyc();
    one("post_flush", 32'hFFF00093, 3'd0, 32'h0, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE);

    // Asynchronous reset with a full pipe.
    out_ready = 1'b0; in_valid = 1'b1;
    instr = 32'hFFF00093; immsrc = 3'd0; cyc();
    instr = 32'h0; immsrc = 3'd6; cyc();
    in_valid = 1'b0;
    cyc();
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check("arst_immop", immop, 32'd0);
    check("arst_fmt_err", {31'b0, fmt_err}, 32'd0);
    q.delete(); held = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    edges++;
    #1;
    out_ready = 1'b1;
    one("post_reset", 32'h123450B7, 3'd1, 32'h0, 32'h12345000, 1'b0, 32'h12345000);

    // Randomized traffic with backpressure and occasional flushes.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      instr     = $urandom;
      immsrc    = 3'($urandom_range(0, 7));
      pc_v      = $urandom;
      cyc();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    n0 = 0;
    while (q.size() > 0 && n0 < 20) begin
      cyc();
      n0++;
    end
    check("drain_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
